// File: rtl/cellrv32_fifo.sv
// cellrv32_fifo: single-clock ring-buffer FIFO with free/avail/half flags.
// The read port is optionally registered, overflow/underflow is optionally
// blocked, and the read data is optionally forced to zero while empty.
// Optional macro CELLRV32_FIFO_LEVEL_EN adds level_o (current entry count).
module cellrv32_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_RSYNC = 1,
  parameter int FIFO_SAFE  = 1,
  parameter int FIFO_GATE  = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  output logic                          half_o,
  input  logic [FIFO_WIDTH-1:0]         wdata_i,
  input  logic                          we_i,
  output logic                          free_o,
  input  logic                          re_i,
  output logic [FIFO_WIDTH-1:0]         rdata_o,
  output logic                          avail_o
`ifdef CELLRV32_FIFO_LEVEL_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  if ((FIFO_DEPTH < 1) || (FIFO_DEPTH > 32768) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("cellrv32_fifo: FIFO_DEPTH must be a power of two in 1..32768");
  end

  logic                  we_ok;
  logic                  re_ok;
  logic [FIFO_WIDTH-1:0] head;

  // Qualify write/read requests; the safe build refuses overflow and underflow
  always_comb begin
    we_ok = we_i & (free_o  | (FIFO_SAFE == 0));
    re_ok = re_i & (avail_o | (FIFO_SAFE == 0));
  end

  if (FIFO_DEPTH == 1) begin : g_single
    logic                  valid_q, valid_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;

    // Single slot: a write fills it, a read empties it, flush wins over both
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
        valid_d = 1'b0;
      end else begin
        if (re_ok) valid_d = 1'b0;
        if (we_ok) begin
          valid_d = 1'b1;
          data_d  = wdata_i;
        end
      end
    end

    // Valid flag is reset; stored data is left as is like the ring memory
    always_ff @(posedge clk_i) begin
      if (rst_i) valid_q <= 1'b0;
      else       valid_q <= valid_d;
      data_q <= data_d;
    end

    assign avail_o = valid_q;
    assign free_o  = ~valid_q;
    assign half_o  = valid_q;
    assign head    = data_q;
`ifdef CELLRV32_FIFO_LEVEL_EN
    assign level_o = valid_q;
`endif
  end else begin : g_ring
    localparam logic [AW:0] HALF_LVL = LW'(FIFO_DEPTH / 2);

    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic [AW:0]           level;
    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Pointer advance; the extra MSB distinguishes full from empty
    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (clear_i) begin
        wptr_d = '0;
        rptr_d = '0;
      end else begin
        if (we_ok) wptr_d = wptr_q + 1'b1;
        if (re_ok) rptr_d = rptr_q + 1'b1;
      end
    end

    // Pointer registers
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
      end
    end

    // Storage array, never reset; a flush simply discards the write
    always_ff @(posedge clk_i) begin
      if (we_ok && !clear_i && !rst_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign level   = wptr_q - rptr_q;
    assign avail_o = |level;
    assign free_o  = ~level[AW];
    assign half_o  = (level >= HALF_LVL);
    assign head    = mem_q[rptr_q[AW-1:0]];
`ifdef CELLRV32_FIFO_LEVEL_EN
    assign level_o = level;
`endif
  end

  if (FIFO_RSYNC != 0) begin : g_rsync
    logic [FIFO_WIDTH-1:0] rdata_q, rdata_d;
    logic                  empty_q, empty_d;

    // Registered head; empty is registered too so gating lines up with data
    always_comb begin
      rdata_d = head;
      empty_d = ~avail_o;
      if (clear_i) begin
        rdata_d = '0;
        empty_d = 1'b1;
      end
    end

    // Read-port registers
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdata_q <= '0;
        empty_q <= 1'b1;
      end else begin
        rdata_q <= rdata_d;
        empty_q <= empty_d;
      end
    end

    assign rdata_o = ((FIFO_GATE != 0) && empty_q) ? '0 : rdata_q;
  end else begin : g_rcomb
    assign rdata_o = ((FIFO_GATE != 0) && !avail_o) ? '0 : head;
  end

endmodule

// File: tb/tb_cellrv32_fifo.sv
// Bench for cellrv32_fifo: two depth-4 instances (registered read, and
// combinational gated read) share one stimulus stream checked against a
// queue model; a depth-1 instance gets a short directed sequence.
module tb_cellrv32_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0] wd = '0;
  logic       a_half, a_free, a_avail, b_half, b_free, b_avail;
  logic [7:0] a_rdata, b_rdata;

  logic       c_rst = 1'b1, c_clr = 1'b0, c_we = 1'b0, c_re = 1'b0;
  logic [7:0] c_wd = '0;
  logic       c_half, c_free, c_avail;
  logic [7:0] c_rdata;

`ifdef CELLRV32_FIFO_LEVEL_EN
  logic [2:0] a_lvl, b_lvl;
  logic [0:0] c_lvl;
`endif

  cellrv32_fifo #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FIFO_RSYNC(1), .FIFO_SAFE(1), .FIFO_GATE(0)) u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .half_o(a_half), .wdata_i(wd), .we_i(we),
    .free_o(a_free), .re_i(re), .rdata_o(a_rdata), .avail_o(a_avail)
`ifdef CELLRV32_FIFO_LEVEL_EN
    , .level_o(a_lvl)
`endif
  );

  cellrv32_fifo #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FIFO_RSYNC(0), .FIFO_SAFE(1), .FIFO_GATE(1)) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .half_o(b_half), .wdata_i(wd), .we_i(we),
    .free_o(b_free), .re_i(re), .rdata_o(b_rdata), .avail_o(b_avail)
`ifdef CELLRV32_FIFO_LEVEL_EN
    , .level_o(b_lvl)
`endif
  );

  cellrv32_fifo #(.FIFO_DEPTH(1), .FIFO_WIDTH(8), .FIFO_RSYNC(1), .FIFO_SAFE(1), .FIFO_GATE(0)) u_c (
    .clk_i(clk), .rst_i(c_rst), .clear_i(c_clr), .half_o(c_half), .wdata_i(c_wd), .we_i(c_we),
    .free_o(c_free), .re_i(c_re), .rdata_o(c_rdata), .avail_o(c_avail)
`ifdef CELLRV32_FIFO_LEVEL_EN
    , .level_o(c_lvl)
`endif
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] q[$];
  logic [7:0] a_exp   = '0;
  bit         a_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare both depth-4 instances against the queue model
  task automatic check_state();
    int n;
    n = q.size();
    chk("a_avail", 32'(a_avail), 32'(n > 0));
    chk("a_free",  32'(a_free),  32'(n < 4));
    chk("a_half",  32'(a_half),  32'(n >= 2));
    chk("b_avail", 32'(b_avail), 32'(n > 0));
    chk("b_free",  32'(b_free),  32'(n < 4));
    chk("b_half",  32'(b_half),  32'(n >= 2));
    chk("b_rdata", 32'(b_rdata), (n > 0) ? 32'(q[0]) : 32'h0);
    if (a_known) chk("a_rdata", 32'(a_rdata), 32'(a_exp));
`ifdef CELLRV32_FIFO_LEVEL_EN
    chk("a_level", 32'(a_lvl), 32'(n));
    chk("b_level", 32'(b_lvl), 32'(n));
`endif
  endtask

  // One clock of stimulus on the shared depth-4 inputs, model update, check
  task automatic step(input bit w, input bit r, input bit c, input bit rs, input logic [7:0] d);
    bit rd, wr;
    we = w; re = r; clr = c; rst = rs; wd = d;
    if (!rs && !c && r && q.size() > 0) chk("pop_b", 32'(b_rdata), 32'(q[0]));
    @(posedge clk);
    if (rs || c) begin
      a_exp = '0; a_known = 1'b1; q.delete();
    end else begin
      a_known = (q.size() > 0);
      if (a_known) a_exp = q[0];
      rd = r && (q.size() > 0);
      wr = w && (q.size() < 4);
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(d);
    end
    @(negedge clk);
    we = 1'b0; re = 1'b0; clr = 1'b0; rst = 1'b0;
    check_state();
  endtask

  task automatic c_step(input bit w, input bit r, input bit c, input bit rs, input logic [7:0] d);
    c_we = w; c_re = r; c_clr = c; c_rst = rs; c_wd = d;
    @(posedge clk);
    @(negedge clk);
    c_we = 1'b0; c_re = 1'b0; c_clr = 1'b0; c_rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    // reset
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // fill past full, then drain
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h22);
    step(1, 0, 0, 0, 8'h33);
    step(1, 0, 0, 0, 8'h44);
    step(1, 0, 0, 0, 8'h55);
    step(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00);
    // simultaneous read/write with two entries, then at full
    step(1, 0, 0, 0, 8'h01);
    step(1, 0, 0, 0, 8'h02);
    step(1, 1, 0, 0, 8'hAA);
    step(0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h03);
    step(1, 0, 0, 0, 8'h04);
    step(1, 1, 0, 0, 8'hBB);
    step(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
    // underflow attempts, then a write that must come back intact
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h5A);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    // read latency on a single write
    step(1, 0, 0, 0, 8'h77);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    // flush with a concurrent write
    step(1, 0, 0, 0, 8'hC1);
    step(1, 0, 0, 0, 8'hC2);
    step(1, 0, 0, 0, 8'hC3);
    step(1, 0, 1, 0, 8'h66);
    step(1, 0, 0, 0, 8'h12);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    // random traffic with rare flushes
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0), 1'b0, 8'($urandom_range(0, 255)));

    // depth-1 instance
    c_step(0, 0, 0, 1, 8'h00);
    chk("c_rst_avail", 32'(c_avail), 32'h0);
    chk("c_rst_free",  32'(c_free),  32'h1);
    chk("c_rst_half",  32'(c_half),  32'h0);
    chk("c_rst_rdata", 32'(c_rdata), 32'h0);
    c_step(1, 0, 0, 0, 8'h9C);
    chk("c_wr_free",  32'(c_free),  32'h0);
    chk("c_wr_half",  32'(c_half),  32'h1);
    chk("c_wr_avail", 32'(c_avail), 32'h1);
    c_step(0, 0, 0, 0, 8'h00);
    chk("c_rdata", 32'(c_rdata), 32'h9C);
    c_step(1, 0, 0, 0, 8'h3E);
    c_step(0, 0, 0, 0, 8'h00);
    chk("c_ovf_rdata", 32'(c_rdata), 32'h9C);
    c_step(1, 1, 0, 0, 8'h3F);
    chk("c_full_wr_rd_avail", 32'(c_avail), 32'h0);
    chk("c_full_wr_rd_free",  32'(c_free),  32'h1);
    c_step(1, 1, 0, 0, 8'h47);
    chk("c_empty_wr_rd_avail", 32'(c_avail), 32'h1);
    c_step(0, 0, 0, 0, 8'h00);
    chk("c_empty_wr_rd_rdata", 32'(c_rdata), 32'h47);
    c_step(1, 0, 1, 0, 8'h88);
    chk("c_clr_avail", 32'(c_avail), 32'h0);
    chk("c_clr_free",  32'(c_free),  32'h1);
    chk("c_clr_rdata", 32'(c_rdata), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
